// File: rtl/min_sec_counter.sv
// min_sec_counter: divides the system clock to a one-second tick, counts
// seconds and minutes 0-59, and pulses hour_en on each 59:59 -> 00:00 wrap.
// Optional BCD views of sec/min are built when MIN_SEC_BCD_EN is defined.
module min_sec_counter #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic       set_en,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       tick,
    output logic       hour_en
`ifdef MIN_SEC_BCD_EN
    ,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;

    // Prescaler, counters and single-cycle strobes; reset > set > run > hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            presc   <= '0;
            sec     <= '0;
            min     <= '0;
            tick    <= 1'b0;
            hour_en <= 1'b0;
        end else if (set_en) begin
            // Presets saturate so the counters never leave 0-59.
            presc   <= '0;
            sec     <= (set_sec > 6'd59) ? 6'd59 : set_sec;
            min     <= (set_min > 6'd59) ? 6'd59 : set_min;
            tick    <= 1'b0;
            hour_en <= 1'b0;
        end else if (run) begin
            tick    <= 1'b0;
            hour_en <= 1'b0;
            if (presc == P_LAST) begin
                presc <= '0;
                tick  <= 1'b1;
                if (sec < 6'd59) begin
                    sec <= sec + 6'd1;
                end else begin
                    sec <= '0;
                    if (min == 6'd59) begin
                        min     <= '0;
                        hour_en <= 1'b1;
                    end else begin
                        min <= min + 6'd1;
                    end
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            // Hold keeps the partial prescale count so timing resumes exactly.
            tick    <= 1'b0;
            hour_en <= 1'b0;
        end
    end

`ifdef MIN_SEC_BCD_EN
    // Binary 0-59 to two BCD digits via range compare, no divider needed.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        if (v >= 6'd50) begin
            tens = 4'd5; rem = v - 6'd50;
        end else if (v >= 6'd40) begin
            tens = 4'd4; rem = v - 6'd40;
        end else if (v >= 6'd30) begin
            tens = 4'd3; rem = v - 6'd30;
        end else if (v >= 6'd20) begin
            tens = 4'd2; rem = v - 6'd20;
        end else if (v >= 6'd10) begin
            tens = 4'd1; rem = v - 6'd10;
        end
        return {tens, 4'(rem)};
    endfunction

    assign sec_bcd = to_bcd(sec);
    assign min_bcd = to_bcd(min);
`endif

endmodule
